// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative radix-2 multiply/divide unit with HI/LO registers
// MULT/MULTU/DIV/DIVU over magnitudes in 32 iterations, then one sign-fix cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q;
  logic               is_div_q, neg_q, neg_rem_q, done_q;
  logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem, hi_fix, lo_fix;

  always_comb begin
    sign_a = ~op[0] & a[WIDTH-1];
    sign_b = ~op[0] & b[WIDTH-1];
    a_mag  = sign_a ? -a : a;
    b_mag  = sign_b ? -b : b;
  end

  // Multiply: add into the upper half, shift right; divide: restoring, quotient enters the LSB.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : {WIDTH{1'b0}})};
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    div_diff = {1'b0, div_sh} - {2'b00, b_q};
    div_ge   = ~div_diff[WIDTH+1];
    div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    if (is_div_q) acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
    else          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      hi_fix = neg_rem_q ? -rem : rem;
      lo_fix = neg_q ? -quo : quo;
    end else begin
      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hi_we) hi_q <= wd;
          if (lo_we) lo_q <= wd;
          if (start) begin
            is_div_q  <= op[1];
            // A zero divisor keeps the quotient at all ones regardless of operand signs.
            neg_q     <= (sign_a ^ sign_b) & (b != '0);
            neg_rem_q <= sign_a;
            a_q       <= a_mag;
            b_q       <= b_mag;
            acc_q     <= '0;
            cnt_q     <= '0;
            state_q   <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (is_div_q) a_q <= a_q << 1;
          else          b_q <= b_q >> 1;
          if (cnt_q == CW'(WIDTH-1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= hi_fix;
          lo_q    <= lo_fix;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit
// Directed vectors push expected {HI,LO}; a monitor checks on every done pulse.
module tb_mul_div_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wd = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  int done_expected = 0;
  logic done_prev = 1'b0;
  logic [63:0] exp_q[$];

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expected result per done pulse.
  always @(negedge clk) begin
    if (done) begin
      done_seen++;
      check("done_width", {63'd0, done_prev}, 64'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got hi=0x%0h lo=0x%0h, expected no done", hi, lo);
      end else begin
        check("result", {hi, lo}, exp_q.pop_front());
      end
    end
    done_prev <= done;
  end

  // Launch an op (optionally in the current cycle), then count busy cycles to the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] expv, input bit now);
    int n;
    if (!now) @(negedge clk);
    exp_q.push_back(expv);
    done_expected++;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(n), 64'd33);
    check("done_at_end", {63'd0, done}, 64'd1);
  endtask

  initial begin
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_op(MULT,  32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    run_op(MULT,  32'hFFFF_FFFC, 32'hFFFF_FFFB, 64'd20,                  1'b0);
    run_op(DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op(DIVU,  32'd100,       32'd7,         {32'd2, 32'd14},         1'b0);
    run_op(DIV,   32'd7,         32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD},  1'b0);
    run_op(DIVU,  32'd5,         32'd0,         {32'd5, 32'hFFFF_FFFF},  1'b0);
    run_op(DIV,   32'hFFFF_FFF9, 32'd0,         {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1'b0);
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000},  1'b0);
    run_op(MULTU, 32'd1234,      32'd0,         64'd0,                   1'b0);

    // Back-to-back: second op launched in the done cycle of the first.
    run_op(MULTU, 32'd6, 32'd7, 64'd42, 1'b0);
    run_op(DIVU,  32'd50, 32'd8, {32'd2, 32'd6}, 1'b1);

    // Mid-op start and MTLO/MTHI while busy are ignored.
    fork
      run_op(MULTU, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b0);
      begin
        repeat (6) @(negedge clk);
        start = 1'b1; op = DIVU; a = 32'd1; b = 32'd1;
        lo_we = 1'b1; hi_we = 1'b1; wd = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
        check("we_while_busy", {hi, lo}, {32'd2, 32'd6});
      end
    join

    // MTHI alongside start: written now, overwritten by the result later.
    @(negedge clk);
    hi_we = 1'b1; wd = 32'h55;
    exp_q.push_back({32'd0, 32'd6});
    done_expected++;
    start = 1'b1; op = MULTU; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    check("mthi_with_start", {32'd0, hi}, {32'd0, 32'h55});
    repeat (34) @(negedge clk);

    // Reset mid-DIV: immediate clear, no done afterwards.
    @(negedge clk);
    start = 1'b1; op = DIV; a = 32'd77; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);

    hi_we = 1'b1; wd = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi", {hi, lo}, {32'h1234, 32'd0});
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'hA5A5_0F0F;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_mtlo", {hi, lo}, {32'hA5A5_0F0F, 32'hA5A5_0F0F});

    repeat (3) @(negedge clk);
    check("done_count", 64'(done_seen), 64'(done_expected));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
